// File: rtl/serdes_tx_framer.sv
// serdes_tx_framer: pulls bytes from the TX FIFO, frames them into packets that
// each start with a K28.5 comma, 8b/10b encodes each symbol with running
// disparity, and shifts every 10-bit code out LSB-first, one bit per clock.
// A comma is also sent whenever the FIFO is empty at the read decision point.
module serdes_tx_framer #(
    parameter int NUM_BYTES_PER_PACKET = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] din,
    output logic       strobout,
    output logic       sym_start,
    output logic       is_comma,
    output logic       rd_out
);

    localparam int SLOT_W = (NUM_BYTES_PER_PACKET > 2) ? $clog2(NUM_BYTES_PER_PACKET) : 1;

    // Codes are written abcdei_fghj with bit a as the MSB.
    localparam logic [9:0] K28_5_RDM = 10'b001111_1010;
    localparam logic [9:0] K28_5_RDP = 10'b110000_0101;
    // K28.5 RD- bit-reversed so that bit a sits in shreg[0].
    localparam logic [9:0] SHREG_RST = 10'b0101111100;

    // 5b/6b codes for the RD- column; the RD+ column is the complement
    // wherever the code is unbalanced, and for D.7.
    localparam logic [5:0] D6_RDM [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // 3b/4b codes for the RD- column (y=7 entry is the primary P7 code);
    // RD+ is the complement when unbalanced, and for D.x.3.
    localparam logic [3:0] D4_RDM [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    logic [3:0]        bit_cnt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic [9:0]        shreg;
    logic              rd_pending;

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] d6, c6;
    logic [3:0] d4, c4;
    logic       unbal6, unbal4, rd6, rd4, use_a7;
    logic [9:0] load_code;
    logic       load_rd;

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    assign x        = din[4:0];
    assign y        = din[7:5];
    assign slot_nxt = slot + SLOT_W'(1);

    // Read decision: only at bit 8, only for a data slot, only if bytes are waiting.
    assign fifo_rd_en = (bit_cnt == 4'd8) && (slot_nxt != '0) && !fifo_empty;
    assign sym_start  = (bit_cnt == 4'd0);
    assign strobout   = shreg[0];

    // Encode the next symbol: data byte if one was read, otherwise K28.5.
    always_comb begin
        d6     = D6_RDM[x];
        unbal6 = ($countones(d6) != 3);
        c6     = (rd_out && (unbal6 || x == 5'd7)) ? ~d6 : d6;
        rd6    = rd_out ^ unbal6;
        // A7 avoids a run of five identical bits across the 6b/4b boundary.
        use_a7 = (y == 3'd7) &&
                 (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                      : (x == 5'd17 || x == 5'd18 || x == 5'd20));
        d4     = use_a7 ? 4'b0111 : D4_RDM[y];
        unbal4 = ($countones(d4) != 2);
        c4     = (rd6 && (unbal4 || y == 3'd3)) ? ~d4 : d4;
        rd4    = rd6 ^ unbal4;
        if (rd_pending) begin
            load_code = {c6, c4};
            load_rd   = rd4;
        end else begin
            load_code = rd_out ? K28_5_RDP : K28_5_RDM;
            load_rd   = ~rd_out;
        end
    end

    // Bit counter, serializer, symbol load and packet slot tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            slot       <= '0;
            shreg      <= SHREG_RST;
            rd_out     <= 1'b1;
            is_comma   <= 1'b1;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
            if (bit_cnt == 4'd9) begin
                bit_cnt  <= 4'd0;
                shreg    <= rev10(load_code);
                rd_out   <= load_rd;
                is_comma <= !rd_pending;
                // Filler and scheduled commas both restart the packet.
                slot     <= rd_pending ? slot_nxt : '0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {1'b0, shreg[9:1]};
            end
        end
    end

endmodule
